// File: rtl/ttl_bus_pkg.sv
// ttl_bus_pkg: shared bus width and receiver FSM encoding
package ttl_bus_pkg;
    localparam int BUS_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;
endpackage

// File: rtl/ttl_fifo2.sv
// ttl_fifo2: 2-entry byte FIFO; head shows the last popped byte while empty
module ttl_fifo2
    import ttl_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [BUS_W-1:0] din,
    output logic [BUS_W-1:0] head,
    output logic             rdy,
    output logic             full
);
    logic [BUS_W-1:0] mem_q [2];
    logic [BUS_W-1:0] last_q;
    logic             wp_q, rp_q;
    logic [1:0]       cnt_q;
    logic             do_push, do_pop;
    assign rdy     = cnt_q != 2'd0;
    assign full    = cnt_q == 2'd2;
    assign do_push = push & ~full;
    assign do_pop  = pop & rdy;
    assign head    = rdy ? mem_q[rp_q] : last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din;
                wp_q        <= ~wp_q;
            end
            if (do_pop) begin
                last_q <= mem_q[rp_q];
                rp_q   <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/sn74ls241_rcv.sv
// sn74ls241_rcv: samples an inverted tristate bus once per strobe and
// queues the re-inverted byte for a ready/ack consumer.
module sn74ls241_rcv
    import ttl_bus_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BUS_W-1:0] bus,
    input  logic             stb_,
    input  logic             ack,
    input  logic             oe_,
    output logic [BUS_W-1:0] q,
    output logic             rdy,
    output logic             full,
    output logic             ovf,
    output logic             flt
);
    localparam logic [2:0] CNT_LAST = 3'(SETTLE - 1);
    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d, flt_q, flt_d;
    logic             push, bad;
    logic [BUS_W-1:0] head;
    // any x/z bit poisons the reduction XOR
    assign bad = (^bus) === 1'bx;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        flt_d   = flt_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stb_) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 3'd0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
                else if (stb_) state_d = ST_IDLE;
                else cnt_d = cnt_q + 3'd1;
            end
            ST_SAMPLE: begin
                state_d = ST_HOLD;
                if (bad) flt_d = 1'b1;
                else if (full) ovf_d = 1'b1;
                else push = 1'b1;
            end
            default: state_d = stb_ ? ST_IDLE : ST_HOLD;
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ovf_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            flt_q   <= flt_d;
        end
    end
    ttl_fifo2 u_fifo (
        .clk  (clk),
        .rst  (clr),
        .push (push),
        .pop  (ack),
        .din  (~bus),
        .head (head),
        .rdy  (rdy),
        .full (full)
    );
    assign ovf = ovf_q;
    assign flt = flt_q;
    assign q   = oe_ ? {BUS_W{1'bz}} : head;
endmodule

// File: doc/sn74ls241_rcv.md
# sn74ls241_rcv

Octal receiver for the far end of a tristate bus driven by an sn74ls240. It samples the inverted bus byte once per driver-enable strobe and re-inverts it, so `q` equals the original source data. Received bytes are buffered in a 2-entry FIFO and handed to the consumer with a ready/ack handshake. Floating or unknown bus bits at the sample point are reported on `flt` instead of being buffered. This is a simulation model for board-level testbenches and is not intended for synthesis.

## Interface
Parameters:
- `SETTLE`, default 2: number of clock cycles from strobe assertion to the bus sample point. Legal range 1..7.

Ports:
- `clk`  input  1: clock; all state changes on the rising edge.
- `clr`  input  1: reset, asynchronous, active-high.
- `bus`  input  8: inverted bus lines, driven by a remote sn74ls240 or floating.
- `stb_`  input  1: driver-enable strobe, active low (mirrors the remote `g1_`/`g2_`).
- `ack`  input  1: consumer pops the FIFO head when `ack` and `rdy` are both high at a rising edge.
- `oe_`  input  1: output enable, active low; `q` is high-Z whenever `oe_`=1.
- `q`  output  8: FIFO head, re-inverted (equals `~bus` at the sample point).
- `rdy`  output  1: FIFO not empty.
- `full`  output  1: FIFO holds 2 entries.
- `ovf`  output  1: sticky overrun flag.
- `flt`  output  1: sticky float/unknown flag.

## Operation
- FSM states:
  - IDLE: `stb_`=0 -> SETTLE with the counter cleared.
  - SETTLE: the counter increments each cycle. When the counter reaches `SETTLE`-1 -> SAMPLE. If `stb_` returns to 1 before that -> IDLE with no capture and no flag.
  - SAMPLE: lasts one cycle and evaluates `bus`.
    - Any bit x/z: set `flt`, nothing is enqueued.
    - Otherwise, FIFO full: set `ovf`, the byte is dropped.
    - Otherwise: enqueue `~bus`.
    - In all cases -> HOLD.
  - HOLD: wait for `stb_`=1 -> IDLE. Exactly one capture per strobe assertion.
- FIFO:
  - 2 entries, 1-bit read and write pointers plus a 2-bit count.
  - `rdy` = (count != 0); `full` = (count == 2).
  - Enqueue and pop in the same cycle: count is unchanged, and the head advances to the new/next entry.
  - Pop when empty (`ack` with `rdy`=0): ignored.
- `q`:
  - With `oe_`=0, `q` is the FIFO head; when empty it is the last-popped value, which is 8'h00 after reset.
  - With `oe_`=1, `q` is 8'bz.
  - The tristate control is combinational and does not depend on `clk`.
- Flags: `ovf` and `flt` are sticky and are cleared only by `clr`. The block has no software clear.

## Timing
- Reset (asynchronous, immediate on `clr`=1):
  - State is IDLE, counter 0.
  - Count 0, pointers 0, storage 8'h00.
  - `rdy`=0, `full`=0, `ovf`=0, `flt`=0.
  - `q`=8'h00 if `oe_`=0, otherwise 8'bz.
- Latency: a falling `stb_` seen at edge N gives the sample at edge N+`SETTLE`. `rdy` rises after edge N+`SETTLE`+1, i.e. it is registered.
- `clr` asserted mid-capture aborts the capture; nothing is enqueued. After `clr` is released with `stb_` still 0, the FSM re-enters SETTLE at the next edge (a new capture).
- `stb_` held low indefinitely gives exactly one capture. `stb_` pulses shorter than `SETTLE` cycles are ignored.
- `ack` acts on a rising edge only. After a pop, `q` changes in the same edge's update.

## Structure
- Shared package `ttl_bus_pkg`:
  - FSM state encoding: IDLE=0, SETTLE=1, SAMPLE=2, HOLD=3.
  - Constant `BUS_W`=8.
- Sub-module `ttl_fifo2`: 2-entry, 8-bit FIFO with push, pop, rdy, full.
  - The top level holds the FSM, the flags and the `q` tristate.
- Testbench pairs this block with an `sn74ls240` instance; the driver's `q_` connects to `bus`, and the driver's `g1_`/`g2_` are tied to `stb_`.

## Test plan
- Pass-through:
  - Stimulus: source `a`=8'hA5, `stb_` low for 4 cycles, `oe_`=0.
  - Response: `bus`=8'h5A, `rdy` rises at edge `SETTLE`+1, `q`=8'hA5.
  - Then pulse `ack`: `rdy`=0.
- FIFO fill and overrun:
  - Stimulus: three strobes with 8'h00, 8'hFF, 8'hC3 and no `ack`.
  - Response: `full`=1 after the second strobe; `ovf`=1 after the third.
  - Popping yields 8'h00 then 8'hFF, then `rdy`=0.
- Float detect:
  - Stimulus: `stb_` low while the driver is disabled (`bus`=8'bz).
  - Response: `flt`=1, `rdy` stays 0. `flt` stays set after later good captures.
- Short strobe:
  - Stimulus: `stb_` low for 1 cycle with `SETTLE`=2.
  - Response: no capture, flags unchanged.
- Simultaneous push/pop:
  - Stimulus: with one entry 8'h11 held, `ack` coincides with the SAMPLE of 8'h22.
  - Response: count stays 1, `q`=8'h22.
- Reset mid-capture and output enable:
  - Stimulus: assert `clr` during SETTLE.
  - Response: all outputs take their reset values immediately; nothing is enqueued.
  - Response: `oe_`=1 gives `q`=8'bz at any time, without a clock edge.
